// File: rtl/alu_pipe_top.sv
// alu_pipe_top: RV32I/RV64I integer ALU behind a LATENCY-deep elastic valid/ready pipeline
// Define ALU_FLAGS_EN to add the out_zero/out_illegal flag outputs.
module alu_pipe_top #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
`ifdef ALU_FLAGS_EN
  ,
  output logic            out_zero,
  output logic            out_illegal
`endif
);
  localparam int L  = LATENCY;
  localparam int F  = (L == 1) ? 0 : 1;
  localparam int N  = L - F;
  localparam int SW = $clog2(XLEN);
`ifdef ALU_FLAGS_EN
  localparam int W = XLEN + 2;
`else
  localparam int W = XLEN;
`endif
  logic [L-1:0] v, ld, v_src;
  logic c, is_r, is_i;
  logic [4:0] op_d, alu_op;
  logic [XLEN-1:0] alu_a, alu_b, y, sra;
  logic [SW-1:0] sh;
  logic [W-1:0] res_d;
  logic [W-1:0] res_q [N];
  logic [W-1:0] res_src [N];
  assign is_r = opcode == 7'b0110011;
  assign is_i = opcode == 7'b0010011;
  // op encoding: {illegal, alt (SUB/SRA), funct3}
  assign op_d = {!(is_r || is_i), funct7[5] && (funct3 == 3'b101 || (funct3 == 3'b000 && is_r)), funct3};
  if (L == 1) begin : g_comb
    assign alu_op = op_d;
    assign alu_a  = a;
    assign alu_b  = b;
  end else begin : g_dec
    logic [4:0] op_q;
    logic [XLEN-1:0] a_q, b_q;
    always_ff @(posedge clk)
      if (rst) begin
        op_q <= '0;
        a_q  <= '0;
        b_q  <= '0;
      end else if (ld[0] && in_valid) begin
        op_q <= op_d;
        a_q  <= a;
        b_q  <= b;
      end
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
  end
  assign sh  = alu_b[SW-1:0];
  assign sra = $signed(alu_a) >>> sh;
  always_comb begin
    case (alu_op[2:0])
      3'b000:  y = alu_op[3] ? alu_a - alu_b : alu_a + alu_b;
      3'b001:  y = alu_a << sh;
      3'b010:  y = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      3'b011:  y = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      3'b100:  y = alu_a ^ alu_b;
      3'b101:  y = alu_op[3] ? sra : alu_a >> sh;
      3'b110:  y = alu_a | alu_b;
      default: y = alu_a & alu_b;
    endcase
    if (alu_op[4]) y = '0;
  end
`ifdef ALU_FLAGS_EN
  assign res_d = {alu_op[4], y == '0, y};
`else
  assign res_d = y;
`endif
  // A stage may load when empty or when its occupant leaves on the same edge.
  always_comb begin
    ld = '0;
    c  = out_ready;
    for (int i = L - 1; i >= 0; i--) begin
      c     = !v[i] || c;
      ld[i] = c;
    end
  end
  assign v_src = L'({v, in_valid});
  always_ff @(posedge clk)
    if (rst) v <= '0;
    else v <= (ld & v_src) | (~ld & v);
  always_comb begin
    res_src[0] = res_d;
    for (int j = 1; j < N; j++) res_src[j] = res_q[j-1];
  end
  always_ff @(posedge clk)
    for (int j = 0; j < N; j++)
      if (rst) res_q[j] <= '0;
      else if (ld[F+j] && v_src[F+j]) res_q[j] <= res_src[j];
  assign in_ready  = ld[0] && !rst;
  assign out_valid = v[L-1];
  assign out_data  = res_q[N-1][XLEN-1:0];
`ifdef ALU_FLAGS_EN
  assign out_zero    = res_q[N-1][XLEN];
  assign out_illegal = res_q[N-1][XLEN+1];
`endif
endmodule

// File: tb/tb_alu_pipe_top.sv
// tb_alu_pipe_top: directed + random checks of alu_pipe_top against a queue-based reference model
// Honours ALU_FLAGS_EN by also checking out_zero/out_illegal.
module tb_alu_pipe_top;
  localparam int XL  = 32;
  localparam int LAT = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [6:0] opcode = 0, funct7 = 0;
  logic [2:0] funct3 = 0;
  logic [XL-1:0] a = 0, b = 0, out_data;
  logic [XL+1:0] obs;
  logic v6 = 0, in_ready1, in_ready3, out_valid1, out_valid3;
  logic [63:0] out_data1, out_data3;
  logic [63:0] a6 = 64'd1, b6 = 64'd63;
`ifdef ALU_FLAGS_EN
  logic out_zero, out_illegal, z1, i1, z3, i3;
  assign obs = {out_illegal, out_zero, out_data};
`else
  assign obs = {2'b00, out_data};
`endif

  alu_pipe_top #(.XLEN(XL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ALU_FLAGS_EN
    , .out_zero(out_zero), .out_illegal(out_illegal)
`endif
  );
  alu_pipe_top #(.XLEN(64), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(in_ready1),
    .opcode(7'h33), .funct3(3'b001), .funct7(7'h00), .a(a6), .b(b6),
    .out_valid(out_valid1), .out_ready(1'b1), .out_data(out_data1)
`ifdef ALU_FLAGS_EN
    , .out_zero(z1), .out_illegal(i1)
`endif
  );
  alu_pipe_top #(.XLEN(64), .LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(in_ready3),
    .opcode(7'h33), .funct3(3'b001), .funct7(7'h00), .a(a6), .b(b6),
    .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3)
`ifdef ALU_FLAGS_EN
    , .out_zero(z3), .out_illegal(i3)
`endif
  );

  int n_vec = 0, n_err = 0, sent;
  logic [XL+1:0] q[$];
  logic hold_v = 0, acc = 0, saw_block;
  logic [XL-1:0] hold_d = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XL-1:0] ref_alu(input logic [6:0] o, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [XL-1:0] x,
                                             input logic [XL-1:0] y);
    int sh;
    logic signed [XL-1:0] sx;
    sh = int'(y % XL);
    sx = x;
    if (o != 7'h33 && o != 7'h13) return '0;
    case (f3)
      3'd0: return (o == 7'h33 && f7[5]) ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return (sx < $signed(y)) ? XL'(1) : '0;
      3'd3: return (x < y) ? XL'(1) : '0;
      3'd4: return x ^ y;
      3'd5: begin
        sx = sx >>> sh;
        return f7[5] ? sx : x >> sh;
      end
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic push_model();
    logic [XL-1:0] d;
    d = ref_alu(opcode, funct3, funct7, a, b);
`ifdef ALU_FLAGS_EN
    q.push_back({opcode != 7'h33 && opcode != 7'h13, d == '0, d});
`else
    q.push_back({2'b00, d});
`endif
  endtask

  // One clock: check outputs at the negedge, record the accept, then move past the posedge.
  task automatic tick();
    @(negedge clk);
    if (hold_v) begin
      chk("stall_valid", 128'(out_valid), 128'(1'b1));
      chk("stall_data", 128'(out_data), 128'(hold_d));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 128'(out_valid), 128'(1'b0));
      else chk("result", 128'(obs), 128'(q.pop_front()));
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    acc = in_valid && in_ready;
    if (acc) push_model();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [XL-1:0] x, input logic [XL-1:0] y);
    opcode = o; funct3 = f3; funct7 = f7; a = x; b = y; in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    chk("send_accept", 128'(acc), 128'(1'b1));
    in_valid = 0;
  endtask

  function automatic logic [XL-1:0] rnd();
    logic [XL-1:0] r;
    r = XL'({$urandom, $urandom});
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r = {1'b1, {(XL-1){1'b0}}};
      3: r = XL'($urandom_range(0, 70));
      default: ;
    endcase
    return r;
  endfunction

  task automatic set_rand();
    int k;
    k = $urandom_range(0, 9);
    opcode = k < 5 ? 7'h33 : k < 9 ? 7'h13 : 7'($urandom);
    funct3 = 3'($urandom);
    funct7 = $urandom_range(0, 1) ? 7'h20 : 7'($urandom);
    a = rnd();
    b = rnd();
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 20 && q.size() > 0; k++) tick();
    tick();
    chk("drain_empty", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
    rst = 0;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1'b1));

    // latency of a single op with the consumer always ready
    opcode = 7'h33; funct3 = 0; funct7 = 0; a = 32'h7FFFFFFF; b = 1; in_valid = 1;
    tick();
    chk("t1_accept", 128'(acc), 128'(1'b1));
    in_valid = 0;
    repeat (LAT - 1) begin
      chk("t1_early", 128'(out_valid), 128'(1'b0));
      tick();
    end
    chk("t1_valid", 128'(out_valid), 128'(1'b1));
    chk("t1_data", 128'(out_data), 128'(32'h80000000));
    tick();

    send(7'h33, 3'd0, 7'h20, 32'h0, 32'h1);
    send(7'h13, 3'd5, 7'h20, 32'h80000000, 32'd4);
    send(7'h33, 3'd3, 7'h00, 32'h1, 32'hFFFFFFFF);
    send(7'h33, 3'd2, 7'h00, 32'h1, 32'hFFFFFFFF);
    send(7'h03, 3'd0, 7'h00, 32'h5, 32'h6);
    send(7'h33, 3'd7, 7'h00, 32'hF0, 32'h0F);
    send(7'h13, 3'd0, 7'h20, 32'h5, 32'h3);
    send(7'h33, 3'd1, 7'h00, 32'h1, 32'h25);
    send(7'h33, 3'd5, 7'h00, 32'h80000000, 32'd31);
    drain();

    // 8-op burst with a 5-cycle consumer stall
    sent = 0;
    saw_block = 0;
    for (int k = 0; k < 40 && (sent < 8 || q.size() > 0); k++) begin
      out_ready = !(k >= 3 && k < 8);
      in_valid = sent < 8;
      if (sent < 8) set_rand();
      if (in_valid && !in_ready) saw_block = 1;
      tick();
      if (acc) sent++;
    end
    chk("burst_sent", 128'(sent), 128'(8));
    chk("burst_in_ready_drop", 128'(saw_block), 128'(1'b1));
    drain();

    for (int k = 0; k < 300; k++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      set_rand();
      tick();
    end
    drain();

    // reset with two ops in flight
    out_ready = 0;
    send(7'h33, 3'd0, 7'h00, 32'h11, 32'h22);
    send(7'h33, 3'd4, 7'h00, 32'h33, 32'h44);
    rst = 1;
    @(posedge clk);
    #1;
    q.delete();
    hold_v = 0;
    chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1'b0));
    rst = 0;
    out_ready = 1;
    #1;
    chk("midrst_release_ready", 128'(in_ready), 128'(1'b1));
    repeat (6) tick();

    // XLEN=64 SLL through LATENCY=1 and LATENCY=3 instances
    v6 = 1;
    @(negedge clk);
    chk("x64_ready_l1", 128'(in_ready1), 128'(1'b1));
    chk("x64_ready_l3", 128'(in_ready3), 128'(1'b1));
    @(posedge clk);
    #1;
    v6 = 0;
    chk("l1_valid", 128'(out_valid1), 128'(1'b1));
    chk("l1_data", 128'(out_data1), 128'(64'h8000000000000000));
    chk("l3_early", 128'(out_valid3), 128'(1'b0));
    @(posedge clk);
    #1;
    chk("l1_consumed", 128'(out_valid1), 128'(1'b0));
    chk("l3_early2", 128'(out_valid3), 128'(1'b0));
    @(posedge clk);
    #1;
    chk("l3_valid", 128'(out_valid3), 128'(1'b1));
    chk("l3_data", 128'(out_data3), 128'(64'h8000000000000000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
